rename_maptable: RTL and testbench

- Speculative register map table for the 3-way dispatch/rename stage.
- Renames source and destination architectural registers into physical tags each cycle, and supplies Told to the ROB.
- Tracks per-tag ready bits, updated from CDB broadcasts.
- On branch recovery it is overwritten wholesale by the architectural map supplied by the retire/ROB/freelist block (recovery_maptable, br_recover_enable).

---
 rtl/rename_maptable.sv | 148 ++++++++++++++
 tb/tb_rename_maptable.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_maptable.sv
`default_nettype none
// ============================================================================
// Module   : rename_maptable
// Purpose  : speculative arch->phys register map with per-entry ready bits,
//            3-way rename lookup with intra-group and CDB bypass
// Revision : 1.0
// ============================================================================
module rename_maptable #(
  parameter int SUPERSCALAR_WAYS = 3,
  parameter int N_ARCH_REG       = 32,
  parameter int N_PHYS_REG       = 64,
  parameter int PR_W             = 6,
  parameter int AR_W             = 5
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [SUPERSCALAR_WAYS-1:0]        dispatch_valid,
  input  logic [SUPERSCALAR_WAYS-1:0]        dispatch_dest_en,
  input  logic [SUPERSCALAR_WAYS*AR_W-1:0]   dispatch_ar_idx,
  input  logic [SUPERSCALAR_WAYS*PR_W-1:0]   dispatch_new_pr,
  input  logic [SUPERSCALAR_WAYS*AR_W-1:0]   src1_ar_idx,
  input  logic [SUPERSCALAR_WAYS*AR_W-1:0]   src2_ar_idx,
  output logic [SUPERSCALAR_WAYS*PR_W-1:0]   src1_pr,
  output logic [SUPERSCALAR_WAYS*PR_W-1:0]   src2_pr,
  output logic [SUPERSCALAR_WAYS-1:0]        src1_ready,
  output logic [SUPERSCALAR_WAYS-1:0]        src2_ready,
  output logic [SUPERSCALAR_WAYS*PR_W-1:0]   told_idx,
  input  logic [SUPERSCALAR_WAYS-1:0]        cdb_valid,
  input  logic [SUPERSCALAR_WAYS*PR_W-1:0]   cdb_pr,
  input  logic                               br_recover_enable,
  input  logic [N_ARCH_REG*PR_W-1:0]         recovery_maptable
);

  localparam int W = SUPERSCALAR_WAYS;

  if (PR_W < $clog2(N_PHYS_REG)) begin : g_bad_pr_w
    $error("rename_maptable: PR_W too narrow for N_PHYS_REG");
  end

  logic [PR_W-1:0]       map_q [N_ARCH_REG];
  logic [PR_W-1:0]       map_d [N_ARCH_REG];
  logic [N_ARCH_REG-1:0] rdy_q;
  logic [N_ARCH_REG-1:0] rdy_d;
  logic [W-1:0]          wr_en;

  function automatic logic cdb_hit(
    input logic [PR_W-1:0]   tag,
    input logic [W-1:0]      vld,
    input logic [W*PR_W-1:0] prs
  );
    logic hit;
    hit = 1'b0;
    for (int c = 0; c < W; c++) begin
      if (vld[c] && (prs[c*PR_W +: PR_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Returns {hit, tag} of the youngest way older than 'way' writing 'ar'.
  function automatic logic [PR_W:0] older_write(
    input logic [AR_W-1:0]   ar,
    input int                way,
    input logic [W-1:0]      en,
    input logic [W*AR_W-1:0] ars,
    input logic [W*PR_W-1:0] prs
  );
    logic [PR_W:0] res;
    res = '0;
    for (int k = 0; k < W; k++) begin
      if ((k < way) && en[k] && (ars[k*AR_W +: AR_W] == ar)) res = {1'b1, prs[k*PR_W +: PR_W]};
    end
    return res;
  endfunction

  always_comb begin
    wr_en = '0;
    for (int j = 0; j < W; j++) begin
      wr_en[j] = dispatch_valid[j] & dispatch_dest_en[j] & (dispatch_ar_idx[j*AR_W +: AR_W] != '0);
    end
  end

  for (genvar j = 0; j < W; j++) begin : g_way
    logic [AR_W-1:0] s1_ar;
    logic [AR_W-1:0] s2_ar;
    logic [AR_W-1:0] d_ar;
    logic [PR_W:0]   s1_byp;
    logic [PR_W:0]   s2_byp;
    logic [PR_W:0]   d_byp;
    logic [PR_W-1:0] s1_tag;
    logic [PR_W-1:0] s2_tag;

    assign s1_ar  = src1_ar_idx[j*AR_W +: AR_W];
    assign s2_ar  = src2_ar_idx[j*AR_W +: AR_W];
    assign d_ar   = dispatch_ar_idx[j*AR_W +: AR_W];
    assign s1_byp = older_write(s1_ar, j, wr_en, dispatch_ar_idx, dispatch_new_pr);
    assign s2_byp = older_write(s2_ar, j, wr_en, dispatch_ar_idx, dispatch_new_pr);
    assign d_byp  = older_write(d_ar, j, wr_en, dispatch_ar_idx, dispatch_new_pr);
    assign s1_tag = s1_byp[PR_W] ? s1_byp[PR_W-1:0] : map_q[s1_ar];
    assign s2_tag = s2_byp[PR_W] ? s2_byp[PR_W-1:0] : map_q[s2_ar];

    // A bypassed tag was allocated this cycle, so it cannot be on the CDB yet.
    assign src1_pr[j*PR_W +: PR_W]  = (s1_ar == '0) ? '0 : s1_tag;
    assign src2_pr[j*PR_W +: PR_W]  = (s2_ar == '0) ? '0 : s2_tag;
    assign src1_ready[j] = (s1_ar == '0) ||
                           (!s1_byp[PR_W] && (rdy_q[s1_ar] || cdb_hit(s1_tag, cdb_valid, cdb_pr)));
    assign src2_ready[j] = (s2_ar == '0) ||
                           (!s2_byp[PR_W] && (rdy_q[s2_ar] || cdb_hit(s2_tag, cdb_valid, cdb_pr)));
    assign told_idx[j*PR_W +: PR_W] = (d_ar == '0) ? '0 :
                                      (d_byp[PR_W] ? d_byp[PR_W-1:0] : map_q[d_ar]);
  end

  always_comb begin
    map_d = map_q;
    rdy_d = rdy_q;
    if (br_recover_enable) begin
      for (int i = 0; i < N_ARCH_REG; i++) begin
        map_d[i] = recovery_maptable[i*PR_W +: PR_W];
      end
      map_d[0] = '0;
      rdy_d    = '1;
    end else begin
      for (int i = 0; i < N_ARCH_REG; i++) begin
        if (!rdy_q[i] && cdb_hit(map_q[i], cdb_valid, cdb_pr)) rdy_d[i] = 1'b1;
      end
      // Ascending order lets the youngest way win and lets dispatch override CDB.
      for (int j = 0; j < W; j++) begin
        if (wr_en[j]) begin
          map_d[dispatch_ar_idx[j*AR_W +: AR_W]] = dispatch_new_pr[j*PR_W +: PR_W];
          rdy_d[dispatch_ar_idx[j*AR_W +: AR_W]] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_ARCH_REG; i++) begin
        map_q[i] <= PR_W'(i);
      end
      rdy_q <= '1;
    end else begin
      map_q <= map_d;
      rdy_q <= rdy_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rename_maptable.sv
`default_nettype none
// ============================================================================
// Module   : tb_rename_maptable
// Purpose  : scoreboard bench for rename_maptable against a sequential model
// Revision : 1.0
// ============================================================================
module tb_rename_maptable;

  localparam int W    = 3;
  localparam int NA   = 32;
  localparam int PR_W = 6;
  localparam int AR_W = 5;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [W-1:0]      dispatch_valid, dispatch_dest_en, cdb_valid;
  logic [W-1:0]      src1_ready, src2_ready;
  logic [W*AR_W-1:0] dispatch_ar_idx, src1_ar_idx, src2_ar_idx;
  logic [W*PR_W-1:0] dispatch_new_pr, cdb_pr, src1_pr, src2_pr, told_idx;
  logic              br_recover_enable;
  logic [NA*PR_W-1:0] recovery_maptable;

  always #5 clock = ~clock;

  rename_maptable dut (
    .clock             (clock),
    .reset             (reset),
    .dispatch_valid    (dispatch_valid),
    .dispatch_dest_en  (dispatch_dest_en),
    .dispatch_ar_idx   (dispatch_ar_idx),
    .dispatch_new_pr   (dispatch_new_pr),
    .src1_ar_idx       (src1_ar_idx),
    .src2_ar_idx       (src2_ar_idx),
    .src1_pr           (src1_pr),
    .src2_pr           (src2_pr),
    .src1_ready        (src1_ready),
    .src2_ready        (src2_ready),
    .told_idx          (told_idx),
    .cdb_valid         (cdb_valid),
    .cdb_pr            (cdb_pr),
    .br_recover_enable (br_recover_enable),
    .recovery_maptable (recovery_maptable)
  );

  // Per-way stimulus in plain integers
  bit d_v[W], d_de[W], c_v[W];
  int d_ar[W], d_np[W], s1[W], s2[W], c_pr[W];
  int rec[NA];
  bit recov;

  // Reference model: architectural view of the table
  int m_map[NA];
  bit m_rdy[NA];
  int t_map[NA];
  bit t_fresh[NA];

  typedef struct packed {
    logic [31:0]               tag;
    logic [W-1:0]              mask;
    logic [W-1:0][PR_W-1:0]    s1p;
    logic [W-1:0][PR_W-1:0]    s2p;
    logic [W-1:0][PR_W-1:0]    told;
    logic [W-1:0]              s1r;
    logic [W-1:0]              s2r;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   finish_req = 1'b0;
  bit   drain_done = 1'b0;

  function automatic bit in_cdb(int pr);
    for (int c = 0; c < W; c++) if (c_v[c] && c_pr[c] == pr) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int look_pr(int ar);
    return (ar == 0) ? 0 : t_map[ar];
  endfunction

  function automatic bit look_rdy(int ar);
    if (ar == 0) return 1'b1;
    if (t_fresh[ar]) return 1'b0;
    return m_rdy[ar] || in_cdb(t_map[ar]);
  endfunction

  task automatic clear_inputs();
    for (int j = 0; j < W; j++) begin
      d_v[j] = 0; d_de[j] = 0; d_ar[j] = 0; d_np[j] = 0;
      s1[j] = 0; s2[j] = 0; c_v[j] = 0; c_pr[j] = 0;
    end
    for (int i = 0; i < NA; i++) rec[i] = 0;
    recov = 0;
  endtask

  task automatic drive();
    for (int j = 0; j < W; j++) begin
      dispatch_valid[j]                  = d_v[j];
      dispatch_dest_en[j]                = d_de[j];
      dispatch_ar_idx[j*AR_W +: AR_W]    = AR_W'(d_ar[j]);
      dispatch_new_pr[j*PR_W +: PR_W]    = PR_W'(d_np[j]);
      src1_ar_idx[j*AR_W +: AR_W]        = AR_W'(s1[j]);
      src2_ar_idx[j*AR_W +: AR_W]        = AR_W'(s2[j]);
      cdb_valid[j]                       = c_v[j];
      cdb_pr[j*PR_W +: PR_W]             = PR_W'(c_pr[j]);
    end
    for (int i = 0; i < NA; i++) recovery_maptable[i*PR_W +: PR_W] = PR_W'(rec[i]);
    br_recover_enable = recov;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NA; i++) begin
      m_map[i] = i;
      m_rdy[i] = 1'b1;
    end
  endtask

  // Rename the group one instruction at a time, oldest first.
  task automatic push_expected(int tag);
    exp_t e;
    e = '0;
    e.tag = 32'(tag);
    for (int i = 0; i < NA; i++) begin
      t_map[i]   = m_map[i];
      t_fresh[i] = 1'b0;
    end
    for (int j = 0; j < W; j++) begin
      e.mask[j] = d_v[j];
      e.s1p[j]  = PR_W'(look_pr(s1[j]));
      e.s1r[j]  = look_rdy(s1[j]);
      e.s2p[j]  = PR_W'(look_pr(s2[j]));
      e.s2r[j]  = look_rdy(s2[j]);
      e.told[j] = PR_W'(look_pr(d_ar[j]));
      if (d_v[j] && d_de[j] && d_ar[j] != 0) begin
        t_map[d_ar[j]]   = d_np[j];
        t_fresh[d_ar[j]] = 1'b1;
      end
    end
    q.push_back(e);
  endtask

  task automatic update_model();
    if (recov) begin
      for (int i = 0; i < NA; i++) begin
        m_map[i] = (i == 0) ? 0 : rec[i];
        m_rdy[i] = 1'b1;
      end
    end else begin
      for (int i = 0; i < NA; i++) if (in_cdb(m_map[i])) m_rdy[i] = 1'b1;
      for (int j = 0; j < W; j++) begin
        if (d_v[j] && d_de[j] && d_ar[j] != 0) begin
          m_map[d_ar[j]] = d_np[j];
          m_rdy[d_ar[j]] = 1'b0;
        end
      end
    end
  endtask

  task automatic run_cycle(int tag);
    @(posedge clock); #1;
    drive();
    if (!recov) push_expected(tag);
    if (!reset) model_reset();
    else        update_model();
  endtask

  task automatic release_reset();
    @(posedge clock); #1;
    clear_inputs();
    drive();
    reset = 1'b1;
  endtask

  task automatic async_reset_check(int tag);
    @(posedge clock); #1;
    drive();
    #1 reset = 1'b0;
    model_reset();
    push_expected(tag);
  endtask

  task automatic chk(input string nm, input int tag, input int way, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s tag=%0d way=%0d: got %0d expected %0d", nm, tag, way, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      for (int j = 0; j < W; j++) begin
        if (mon_e.mask[j]) begin
          chk("src1_pr",    int'(mon_e.tag), j, int'(src1_pr[j*PR_W +: PR_W]), int'(mon_e.s1p[j]));
          chk("src1_ready", int'(mon_e.tag), j, int'(src1_ready[j]),           int'(mon_e.s1r[j]));
          chk("src2_pr",    int'(mon_e.tag), j, int'(src2_pr[j*PR_W +: PR_W]), int'(mon_e.s2p[j]));
          chk("src2_ready", int'(mon_e.tag), j, int'(src2_ready[j]),           int'(mon_e.s2r[j]));
          chk("told_idx",   int'(mon_e.tag), j, int'(told_idx[j*PR_W +: PR_W]), int'(mon_e.told[j]));
        end
      end
    end else if (finish_req && !drain_done) begin
      chk("queue_drained", 0, 0, q.size(), 0);
      drain_done = 1'b1;
    end
  end

  initial begin
    clear_inputs();
    drive();
    model_reset();
    #1 reset = 1'b0;

    // Lookup while held in reset, then just after release
    d_v[0] = 1; s1[0] = 5; s2[0] = 31; d_ar[0] = 9;
    run_cycle(1);
    release_reset();
    clear_inputs(); d_v[0] = 1; s1[0] = 5; s2[0] = 31; d_ar[0] = 12;
    run_cycle(2);

    // Three independent renames, then read them back
    clear_inputs();
    for (int j = 0; j < W; j++) begin
      d_v[j] = 1; d_de[j] = 1; d_ar[j] = 17 + j; d_np[j] = 40 + j;
    end
    run_cycle(3);
    clear_inputs();
    for (int j = 0; j < W; j++) d_v[j] = 1;
    s1[0] = 17; s2[0] = 18; s1[1] = 19; s2[1] = 18; s1[2] = 17; s2[2] = 19;
    run_cycle(4);

    // Same-group dependency chain on r7
    clear_inputs();
    d_v[0] = 1; d_de[0] = 1; d_ar[0] = 7; d_np[0] = 50;
    d_v[1] = 1; d_de[1] = 1; d_ar[1] = 7; d_np[1] = 51; s1[1] = 7;
    d_v[2] = 1; s1[2] = 7;
    run_cycle(5);
    clear_inputs(); d_v[0] = 1; s1[0] = 7; d_ar[0] = 7;
    run_cycle(6);

    // CDB wakeup bypass, then CDB against a same-cycle re-rename
    clear_inputs(); d_v[0] = 1; d_de[0] = 1; d_ar[0] = 3; d_np[0] = 44;
    run_cycle(7);
    clear_inputs(); d_v[0] = 1; s1[0] = 3; c_v[1] = 1; c_pr[1] = 44;
    run_cycle(8);
    clear_inputs(); d_v[0] = 1; s1[0] = 3;
    run_cycle(9);
    clear_inputs(); d_v[0] = 1; d_de[0] = 1; d_ar[0] = 3; d_np[0] = 44;
    run_cycle(10);
    clear_inputs(); d_v[0] = 1; d_de[0] = 1; d_ar[0] = 3; d_np[0] = 45; c_v[1] = 1; c_pr[1] = 44;
    run_cycle(11);
    clear_inputs(); d_v[0] = 1; s1[0] = 3;
    run_cycle(12);

    // Recovery swallows a same-cycle dispatch
    clear_inputs(); recov = 1;
    for (int i = 0; i < NA; i++) rec[i] = (i == 0) ? 0 : 63 - i;
    d_v[0] = 1; d_de[0] = 1; d_ar[0] = 4; d_np[0] = 20;
    run_cycle(13);
    clear_inputs(); d_v[0] = 1; s1[0] = 4; s2[0] = 10; d_ar[0] = 4;
    run_cycle(14);

    // r0 is never renamed
    clear_inputs();
    d_v[0] = 1; d_de[0] = 1; d_ar[0] = 0; d_np[0] = 33;
    d_v[1] = 1; s1[1] = 0; s2[1] = 5;
    run_cycle(15);
    clear_inputs(); d_v[0] = 1; s1[0] = 0; s2[0] = 0; d_ar[0] = 0;
    run_cycle(16);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      clear_inputs();
      for (int j = 0; j < W; j++) begin
        d_v[j]  = ($urandom_range(0, 3) != 0);
        d_de[j] = $urandom_range(0, 1);
        d_ar[j] = $urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31);
        d_np[j] = $urandom_range(0, 63);
        s1[j]   = $urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31);
        s2[j]   = $urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31);
        c_v[j]  = $urandom_range(0, 1);
        c_pr[j] = $urandom_range(0, 3) != 0 ? m_map[$urandom_range(0, 7)] : $urandom_range(0, 63);
      end
      recov = ($urandom_range(0, 19) == 0);
      if (recov) for (int i = 0; i < NA; i++) rec[i] = $urandom_range(0, 63);
      run_cycle(100 + n);
    end

    // Asynchronous reset in the middle of a cycle after renames
    clear_inputs();
    for (int j = 0; j < W; j++) begin
      d_v[j] = 1; d_de[j] = 1; d_ar[j] = 20 + j; d_np[j] = 10 + j;
    end
    run_cycle(600);
    clear_inputs();
    for (int j = 0; j < W; j++) begin
      d_v[j] = 1; s1[j] = 20 + j; s2[j] = 22 - j; d_ar[j] = 21;
    end
    async_reset_check(601);
    release_reset();
    clear_inputs(); d_v[0] = 1; s1[0] = 20; s2[0] = 22; d_ar[0] = 21;
    run_cycle(602);

    @(posedge clock); #1;
    clear_inputs();
    drive();
    finish_req = 1'b1;
    for (int i = 0; i < 10 && !drain_done; i++) @(negedge clock);
    #1;
    if (!drain_done) begin
      $display("FAIL monitor_drain: queue check never reached");
      $fatal(1, "monitor stalled");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
